// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single shared memory port.
// Requester 0 is instruction fetch and requester 1 is data; each access has a bounded wait.
module mem_port_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic        we0,
    input  logic        we1,
    output logic        ack0,
    output logic        ack1,
    output logic [31:0] rdata,
    output logic        err,
    output logic        sel,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic        last_grant;
    logic [7:0]  wait_cnt;
    logic        any_req;
    logic        win;
    logic        finish;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1)
            win = ~last_grant;
        else
            win = req1;
    end

    assign finish = mem_ready || (wait_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            wait_cnt   <= 8'd0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            sel        <= 1'b0;
            rdata      <= 32'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state      <= ACCESS;
                        sel        <= win;
                        last_grant <= win;
                        mem_addr   <= win ? addr1 : addr0;
                        mem_wdata  <= win ? wdata1 : wdata0;
                        mem_we     <= win ? we1 : we0;
                        mem_req    <= 1'b1;
                        busy       <= 1'b1;
                        wait_cnt   <= 8'd0;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        // A real completion wins over a timeout in the same cycle.
                        rdata   <= mem_ready ? mem_rdata : 32'd0;
                        err     <= ~mem_ready;
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        ack0    <= ~sel;
                        ack1    <= sel;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reads, writes, ties, timeout, reset abort, fairness.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic        ack0, ack1, err, sel, busy, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1),
        .rdata(rdata), .err(err), .sel(sel), .busy(busy),
        .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int cnt;
        int nack;

        // Reset state
        step();
        step();
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_ack1", 32'(ack1), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_sel", 32'(sel), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        reset = 1'b0;

        // Single read from requester 0, ready on 2nd ACCESS cycle
        req0 = 1'b1; addr0 = 32'h0040_0000; we0 = 1'b0;
        check("idle_no_req_mem_req", 32'(mem_req), 32'd0);
        step();
        check("rd_mem_req", 32'(mem_req), 32'd1);
        check("rd_mem_addr", mem_addr, 32'h0040_0000);
        check("rd_sel", 32'(sel), 32'd0);
        check("rd_mem_we", 32'(mem_we), 32'd0);
        check("rd_busy", 32'(busy), 32'd1);
        check("rd_no_ack_yet", 32'(ack0), 32'd0);
        step();
        check("rd_mem_req_2", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h8C01_0004;
        step();
        check("rd_ack0", 32'(ack0), 32'd1);
        check("rd_ack1", 32'(ack1), 32'd0);
        check("rd_rdata", rdata, 32'h8C01_0004);
        check("rd_err", 32'(err), 32'd0);
        check("rd_done_mem_req", 32'(mem_req), 32'd0);
        check("rd_done_busy", 32'(busy), 32'd1);
        req0 = 1'b0; mem_ready = 1'b0;
        step();
        check("rd_ack0_pulse", 32'(ack0), 32'd0);
        check("rd_idle_busy", 32'(busy), 32'd0);

        // Tie right after reset: requester 0 first
        reset = 1'b1;
        step();
        reset = 1'b0;
        req0 = 1'b1; addr0 = 32'h0040_0010;
        req1 = 1'b1; addr1 = 32'h1001_0020; we1 = 1'b0;
        mem_rdata = 32'h1234_5678;
        step();
        check("tie_sel0", 32'(sel), 32'd0);
        check("tie_addr0", mem_addr, 32'h0040_0010);
        mem_ready = 1'b1;
        step();
        check("tie_ack0_first", 32'(ack0), 32'd1);
        check("tie_ack1_not_first", 32'(ack1), 32'd0);
        req0 = 1'b0; mem_ready = 1'b0;
        step();
        step();
        check("tie_sel1", 32'(sel), 32'd1);
        check("tie_addr1", mem_addr, 32'h1001_0020);
        mem_ready = 1'b1;
        step();
        check("tie_ack1_second", 32'(ack1), 32'd1);
        check("tie_ack0_second", 32'(ack0), 32'd0);
        req1 = 1'b0; mem_ready = 1'b0;
        step();

        // Write from requester 1
        req1 = 1'b1; addr1 = 32'h1001_0000; wdata1 = 32'hDEAD_BEEF; we1 = 1'b1;
        step();
        check("wr_mem_we", 32'(mem_we), 32'd1);
        check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_mem_addr", mem_addr, 32'h1001_0000);
        check("wr_sel", 32'(sel), 32'd1);
        addr1 = 32'hFFFF_FFFF; wdata1 = 32'h0;
        step();
        check("wr_addr_held", mem_addr, 32'h1001_0000);
        check("wr_wdata_held", mem_wdata, 32'hDEAD_BEEF);
        mem_ready = 1'b1;
        step();
        check("wr_ack1", 32'(ack1), 32'd1);
        check("wr_ack0", 32'(ack0), 32'd0);
        req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
        step();

        // Timeout: mem_ready never comes, mem_rdata nonzero
        req0 = 1'b1; addr0 = 32'h0040_0100;
        step();
        cnt = 0;
        while (mem_req && cnt < 40) begin
            cnt++;
            step();
        end
        check("to_mem_req_cycles", 32'(cnt), 32'd16);
        check("to_ack0", 32'(ack0), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_rdata", rdata, 32'd0);
        req0 = 1'b0;
        step();

        // mem_ready while idle is ignored
        mem_ready = 1'b1;
        step();
        check("idle_ready_ack0", 32'(ack0), 32'd0);
        check("idle_ready_ack1", 32'(ack1), 32'd0);
        check("idle_ready_busy", 32'(busy), 32'd0);
        mem_ready = 1'b0;

        // Reset mid-access: last grant was 0, so this tie grants 1
        req0 = 1'b1; req1 = 1'b1; addr0 = 32'h0040_0200; addr1 = 32'h1001_0200;
        step();
        check("ra_sel1", 32'(sel), 32'd1);
        step();
        step();
        check("ra_3rd_access", 32'(mem_req), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("ra_mem_req", 32'(mem_req), 32'd0);
        check("ra_ack0", 32'(ack0), 32'd0);
        check("ra_ack1", 32'(ack1), 32'd0);
        check("ra_busy", 32'(busy), 32'd0);
        step();
        check("ra_ack1_after", 32'(ack1), 32'd0);
        check("ra_regrant_sel0", 32'(sel), 32'd0);
        check("ra_regrant_req", 32'(mem_req), 32'd1);

        // Fairness: both held, completion always ready
        mem_ready = 1'b1;
        nack = 0;
        cnt = 0;
        while (nack < 6 && cnt < 60) begin
            step();
            cnt++;
            check("fair_no_double_ack", 32'(ack0 & ack1), 32'd0);
            if (ack0 || ack1) begin
                check($sformatf("fair_ack_%0d", nack), 32'(ack1), 32'(nack % 2));
                nack++;
            end
        end
        check("fair_ack_count", 32'(nack), 32'd6);
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
